mem_port_arbiter: RTL and testbench

- Shares the single unified memory port of the multi-cycle CPU between the instruction-fetch requester (STATE_IF) and the data requester (STATE_MEM, LW/SW).
- Provides a registered req/ack handshake to both requesters and a req/ready handshake toward a variable-latency memory.
- Includes a starvation guard for fetch and a watchdog timeout that reports a hung memory.
- Sits between the control FSM/datapath and the memory model; the control FSM holds its state until the ack arrives.

---
 rtl/mem_port_arbiter_pkg.sv | 26 ++
 rtl/mem_port_arbiter_if.sv | 42 ++++
 rtl/mem_port_arbiter_wdog.sv | 32 +++
 rtl/mem_port_arbiter.sv | 143 ++++++++++++++
 tb/tb_mem_port_arbiter.sv | 276 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/mem_port_arbiter_pkg.sv
// Shared types and constants for the unified memory-port arbiter.
// Holds the arbiter state encoding and default timing limits.
package mem_port_arbiter_pkg;

  localparam int ARB_STATE_LEN        = 2;
  localparam int DEFAULT_TIMEOUT      = 255;
  localparam int DEFAULT_STARVE_LIMIT = 4;
  localparam int WDOG_W               = 8;

  typedef enum logic [ARB_STATE_LEN-1:0] {
    ARB_IDLE   = 2'd0,
    ARB_WAIT_I = 2'd1,
    ARB_WAIT_D = 2'd2,
    ARB_RESP   = 2'd3
  } arb_state_t;

  typedef enum logic {
    OWNER_I = 1'b0,
    OWNER_D = 1'b1
  } arb_owner_t;

  function automatic logic is_wait(input arb_state_t s);
    return (s == ARB_WAIT_I) || (s == ARB_WAIT_D);
  endfunction

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Requester and memory-side signals of the arbiter, bundled as one interface.
// The master modport is the arbiter's view; slave is the surrounding system's view.
interface mem_port_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);

  logic              i_req;
  logic [ADDR_W-1:0] i_addr;
  logic              i_ack;
  logic [DATA_W-1:0] i_rdata;

  logic              d_req;
  logic              d_we;
  logic [ADDR_W-1:0] d_addr;
  logic [DATA_W-1:0] d_wdata;
  logic              d_ack;
  logic [DATA_W-1:0] d_rdata;

  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_ready;
  logic [DATA_W-1:0] mem_rdata;

  logic              err;
  logic              busy;

  modport master (
    input  i_req, i_addr, d_req, d_we, d_addr, d_wdata, mem_ready, mem_rdata,
    output i_ack, i_rdata, d_ack, d_rdata, mem_req, mem_we, mem_addr, mem_wdata,
           err, busy
  );

  modport slave (
    output i_req, i_addr, d_req, d_we, d_addr, d_wdata, mem_ready, mem_rdata,
    input  i_ack, i_rdata, d_ack, d_rdata, mem_req, mem_we, mem_addr, mem_wdata,
           err, busy
  );

endinterface

// File: rtl/mem_port_arbiter_wdog.sv
// Watchdog for a pending memory request: counts wait cycles and flags the
// TIMEOUT-th one so the arbiter can abort unless mem_ready arrives in it.
module mem_arb_wdog
  import mem_port_arbiter_pkg::*;
#(
  parameter int TIMEOUT = DEFAULT_TIMEOUT
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic en,
  output logic expired
);

  localparam logic [WDOG_W-1:0] LAST = WDOG_W'(TIMEOUT - 1);

  logic [WDOG_W-1:0] cnt_q;

  // cnt_q holds the number of wait cycles already completed before this one
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (clear) begin
      cnt_q <= '0;
    end else if (en && (cnt_q != LAST)) begin
      cnt_q <= cnt_q + WDOG_W'(1);
    end
  end

  assign expired = en && (cnt_q == LAST);

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one memory port between instruction fetch and data access, with a
// fetch starvation guard and a watchdog that aborts hung memory requests.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int ADDR_W       = 32,
  parameter int DATA_W       = 32,
  parameter int STARVE_LIMIT = DEFAULT_STARVE_LIMIT,
  parameter int TIMEOUT      = DEFAULT_TIMEOUT
) (
  input logic               clk,
  input logic               rst_n,
  mem_port_arbiter_if.master bus
);

  localparam int                  STARVE_W   = $clog2(STARVE_LIMIT + 1);
  localparam logic [STARVE_W-1:0] STARVE_MAX = STARVE_W'(STARVE_LIMIT);

  arb_state_t         state_q;
  arb_state_t         state_d;
  arb_owner_t         owner_q;
  logic               grant_i;
  logic               grant_d;
  logic               in_wait;
  logic               in_resp;
  logic               wd_clear;
  logic               wd_expired;
  logic               starved;
  logic               we_q;
  logic               err_q;
  logic [ADDR_W-1:0]  addr_q;
  logic [DATA_W-1:0]  wdata_q;
  logic [DATA_W-1:0]  rdata_q;
  logic [STARVE_W-1:0] starve_q;

  assign in_wait  = is_wait(state_q);
  assign in_resp  = (state_q == ARB_RESP);
  assign wd_clear = !in_wait;
  assign starved  = bus.i_req && (starve_q == STARVE_MAX);

  mem_arb_wdog #(
    .TIMEOUT (TIMEOUT)
  ) u_wdog (
    .clk     (clk),
    .rst_n   (rst_n),
    .clear   (wd_clear),
    .en      (in_wait),
    .expired (wd_expired)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ARB_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Data wins ties unless fetch has already lost STARVE_LIMIT times in a row
  always_comb begin
    state_d = state_q;
    grant_i = 1'b0;
    grant_d = 1'b0;
    case (state_q)
      ARB_IDLE: begin
        if (bus.d_req && !starved) begin
          grant_d = 1'b1;
          state_d = ARB_WAIT_D;
        end else if (bus.i_req) begin
          grant_i = 1'b1;
          state_d = ARB_WAIT_I;
        end
      end
      ARB_WAIT_I, ARB_WAIT_D: begin
        if (bus.mem_ready || wd_expired) begin
          state_d = ARB_RESP;
        end
      end
      ARB_RESP: begin
        state_d = ARB_IDLE;
      end
      default: begin
        state_d = ARB_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      owner_q <= OWNER_I;
      addr_q  <= '0;
      we_q    <= 1'b0;
      wdata_q <= '0;
    end else if (grant_d || grant_i) begin
      owner_q <= grant_d ? OWNER_D : OWNER_I;
      addr_q  <= grant_d ? bus.d_addr : bus.i_addr;
      we_q    <= grant_d && bus.d_we;
      wdata_q <= grant_d ? bus.d_wdata : '0;
    end
  end

  // A ready in the expiring cycle still counts as success
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else if (in_wait) begin
      if (bus.mem_ready) begin
        rdata_q <= we_q ? '0 : bus.mem_rdata;
        err_q   <= 1'b0;
      end else if (wd_expired) begin
        rdata_q <= '0;
        err_q   <= 1'b1;
      end
    end else if (in_resp) begin
      rdata_q <= '0;
      err_q   <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      starve_q <= '0;
    end else if (grant_i) begin
      starve_q <= '0;
    end else if (grant_d && bus.i_req && (starve_q != STARVE_MAX)) begin
      starve_q <= starve_q + STARVE_W'(1);
    end
  end

  assign bus.mem_req   = in_wait;
  assign bus.mem_we    = in_wait && we_q;
  assign bus.mem_addr  = in_wait ? addr_q : '0;
  assign bus.mem_wdata = in_wait ? wdata_q : '0;

  assign bus.i_ack   = in_resp && (owner_q == OWNER_I);
  assign bus.d_ack   = in_resp && (owner_q == OWNER_D);
  assign bus.i_rdata = bus.i_ack ? rdata_q : '0;
  assign bus.d_rdata = bus.d_ack ? rdata_q : '0;
  assign bus.err     = in_resp && err_q;
  assign bus.busy    = (state_q != ARB_IDLE);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: directed scenarios followed by
// randomized request/latency mixes checked against a transaction-level model.
module tb_mem_port_arbiter;

  localparam int TIMEOUT_V = 255;
  localparam int STARVE_V  = 4;

  logic clk;
  logic rst_n;

  mem_port_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();

  mem_port_arbiter #(
    .ADDR_W       (32),
    .DATA_W       (32),
    .STARVE_LIMIT (STARVE_V),
    .TIMEOUT      (TIMEOUT_V)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int testsRun;
  int testsFailed;

  bit          iPend;
  logic [31:0] iAddr;
  bit          dPend;
  bit          dWe;
  logic [31:0] dAddr;
  logic [31:0] dWdata;
  int          starve;
  int          memLatency;
  bit          scramble;
  logic [31:0] memArr [logic [31:0]];

  function automatic logic [31:0] memRead(input logic [31:0] a);
    if (memArr.exists(a)) return memArr[a];
    return (a * 32'h9E37_79B9) ^ 32'h1234_5678;
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    testsRun++;
    assert (obs === exp) else begin
      testsFailed++;
      $error("[TB] FAIL %s: observed %08h expected %08h", tag, obs, exp);
    end
  endtask

  task automatic checkIdle(input string tag);
    checkOutput({tag, "_mem_req"}, {31'd0, bus.mem_req}, 32'd0);
    checkOutput({tag, "_mem_addr"}, bus.mem_addr, 32'd0);
    checkOutput({tag, "_busy"}, {31'd0, bus.busy}, 32'd0);
    checkOutput({tag, "_i_ack"}, {31'd0, bus.i_ack}, 32'd0);
    checkOutput({tag, "_d_ack"}, {31'd0, bus.d_ack}, 32'd0);
    checkOutput({tag, "_err"}, {31'd0, bus.err}, 32'd0);
    checkOutput({tag, "_i_rdata"}, bus.i_rdata, 32'd0);
    checkOutput({tag, "_d_rdata"}, bus.d_rdata, 32'd0);
  endtask

  task automatic applyStimulus();
    bus.i_req   = iPend;
    bus.i_addr  = iPend ? iAddr : $urandom;
    bus.d_req   = dPend;
    bus.d_we    = dPend ? dWe : 1'($urandom_range(0, 1));
    bus.d_addr  = dPend ? dAddr : $urandom;
    bus.d_wdata = dPend ? dWdata : $urandom;
  endtask

  task automatic newFetch();
    iPend = 1'b1;
    iAddr = 32'($urandom_range(0, 15)) << 2;
  endtask

  task automatic newData();
    dPend  = 1'b1;
    dWe    = 1'($urandom_range(0, 1));
    dAddr  = 32'($urandom_range(0, 15)) << 2;
    dWdata = $urandom;
  endtask

  // One arbitration round: drive pending requests now, follow the winner to its ack
  task automatic runRound(output bit wonD);
    bit          useD;
    bit          ok;
    int          ackAt;
    logic [31:0] expAddr;
    logic [31:0] expRdata;
    bit          expWe;
    useD = dPend && !(iPend && (starve == STARVE_V));
    if (useD) begin
      if (iPend && (starve < STARVE_V)) starve++;
    end else begin
      starve = 0;
    end
    ok       = (memLatency >= 0) && (memLatency < TIMEOUT_V);
    ackAt    = ok ? memLatency + 2 : TIMEOUT_V + 1;
    expAddr  = useD ? dAddr : iAddr;
    expWe    = useD && dWe;
    expRdata = (!ok || expWe) ? 32'd0 : memRead(expAddr);
    applyStimulus();
    for (int k = 1; k <= ackAt; k++) begin
      @(negedge clk);
      if ((k == 1) && scramble) begin
        if (useD) begin
          bus.d_addr  = bus.d_addr ^ 32'h0000_0F00;
          bus.d_wdata = ~bus.d_wdata;
        end else begin
          bus.i_addr = bus.i_addr ^ 32'h0000_0F00;
        end
      end
      if (k < ackAt) begin
        checkOutput("wait_mem_req", {31'd0, bus.mem_req}, 32'd1);
        checkOutput("wait_mem_addr", bus.mem_addr, expAddr);
        checkOutput("wait_mem_we", {31'd0, bus.mem_we}, {31'd0, expWe});
        if (expWe) checkOutput("wait_mem_wdata", bus.mem_wdata, dWdata);
        checkOutput("wait_i_ack", {31'd0, bus.i_ack}, 32'd0);
        checkOutput("wait_d_ack", {31'd0, bus.d_ack}, 32'd0);
        checkOutput("wait_busy", {31'd0, bus.busy}, 32'd1);
      end else begin
        checkOutput("ack_mem_req", {31'd0, bus.mem_req}, 32'd0);
        checkOutput("ack_i_ack", {31'd0, bus.i_ack}, {31'd0, !useD});
        checkOutput("ack_d_ack", {31'd0, bus.d_ack}, {31'd0, useD});
        checkOutput("ack_i_rdata", bus.i_rdata, useD ? 32'd0 : expRdata);
        checkOutput("ack_d_rdata", bus.d_rdata, useD ? expRdata : 32'd0);
        checkOutput("ack_err", {31'd0, bus.err}, {31'd0, !ok});
        checkOutput("ack_busy", {31'd0, bus.busy}, 32'd1);
      end
    end
    if (expWe && ok) memArr[expAddr] = dWdata;
    @(negedge clk);
    checkIdle("after_ack");
    wonD = useD;
    if (useD) dPend = 1'b0;
    else      iPend = 1'b0;
  endtask

  // Memory model: answers after memLatency wait cycles, emits stray readies while idle
  initial begin
    bit prevReq;
    int waitCnt;
    prevReq       = 1'b0;
    waitCnt       = 0;
    bus.mem_ready = 1'b0;
    bus.mem_rdata = '0;
    forever begin
      @(negedge clk);
      if (bus.mem_req) begin
        if (!prevReq) waitCnt = 0;
        else          waitCnt++;
        bus.mem_ready = (memLatency >= 0) && (waitCnt == memLatency);
        if (bus.mem_ready && !bus.mem_we) bus.mem_rdata = memRead(bus.mem_addr);
        else                              bus.mem_rdata = $urandom;
      end else begin
        bus.mem_ready = ($urandom_range(0, 3) == 0);
        bus.mem_rdata = $urandom;
      end
      prevReq = bus.mem_req;
    end
  end

  initial begin
    #3_000_000;
    $display("[TB] FAIL global_timeout: simulation did not finish within the time limit");
    $fatal(1, "[TB] global timeout");
  end

  initial begin
    bit       wonD;
    bit [5:0] order;
    testsRun    = 0;
    testsFailed = 0;
    starve      = 0;
    iPend       = 1'b0;
    dPend       = 1'b0;
    dWe         = 1'b0;
    iAddr       = '0;
    dAddr       = '0;
    dWdata      = '0;
    memLatency  = 0;
    scramble    = 1'b0;
    rst_n       = 1'b0;
    applyStimulus();

    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    checkIdle("reset");

    // Single fetch, memory answers two cycles after mem_req rises
    memArr[32'h0000_0040] = 32'h2008_0005;
    iPend = 1'b1;
    iAddr = 32'h0000_0040;
    memLatency = 2;
    runRound(wonD);
    checkOutput("fetch_winner", {31'd0, wonD}, 32'd0);

    // Store with zero-latency memory
    dPend = 1'b1; dWe = 1'b1; dAddr = 32'h0000_0010; dWdata = 32'hDEAD_BEEF;
    memLatency = 0;
    runRound(wonD);
    checkOutput("store_winner", {31'd0, wonD}, 32'd1);

    // Both requesters always pending: fetch forced in after four data wins
    order = 6'b101111;
    memLatency = 0;
    for (int r = 0; r < 6; r++) begin
      if (!iPend) newFetch();
      if (!dPend) newData();
      runRound(wonD);
      checkOutput("starve_order", {31'd0, wonD}, {31'd0, order[r]});
    end

    // Hung memory: load aborts with err
    iPend = 1'b0;
    dPend = 1'b1; dWe = 1'b0; dAddr = 32'h0000_0030; dWdata = $urandom;
    memLatency = -1;
    runRound(wonD);

    // Ready in the last allowed cycle is still a success
    dPend = 1'b1; dWe = 1'b0; dAddr = 32'h0000_0034;
    memLatency = TIMEOUT_V - 1;
    runRound(wonD);

    // Asynchronous reset while a fetch waits on memory
    iPend = 1'b1; iAddr = 32'h0000_0020;
    memLatency = -1;
    applyStimulus();
    repeat (3) @(negedge clk);
    checkOutput("pre_reset_mem_req", {31'd0, bus.mem_req}, 32'd1);
    rst_n = 1'b0;
    #1;
    checkIdle("async_reset");
    repeat (2) begin
      @(negedge clk);
      checkOutput("reset_no_ack", {31'd0, bus.i_ack}, 32'd0);
    end
    rst_n  = 1'b1;
    starve = 0;
    checkIdle("post_release");
    iAddr = 32'h0000_0024;
    memLatency = 3;
    runRound(wonD);
    checkOutput("post_reset_winner", {31'd0, wonD}, 32'd0);

    // Randomized mix of requesters, latencies, timeouts and payload scrambles
    for (int n = 0; n < 150; n++) begin
      int sel;
      if (!iPend && ($urandom_range(0, 3) != 0)) newFetch();
      if (!dPend && ($urandom_range(0, 3) != 0)) newData();
      if (!iPend && !dPend) newFetch();
      sel = $urandom_range(0, 99);
      if (sel < 3)      memLatency = -1;
      else if (sel < 6) memLatency = TIMEOUT_V - 1;
      else              memLatency = $urandom_range(0, 5);
      scramble = ($urandom_range(0, 4) == 0);
      runRound(wonD);
    end

    iPend = 1'b0;
    dPend = 1'b0;
    scramble = 1'b0;
    applyStimulus();
    @(negedge clk);
    checkIdle("final");

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
